// File: rtl/quad_decoder.sv
// Quadrature encoder front end: 2-FF synchroniser, per-phase level filter,
// and a transition decoder that drives a loadable modulo-2^WIDTH position count.
module quad_decoder #(
  parameter int WIDTH      = 12,
  parameter int FILTER_LEN = 3
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             enc_a_in,
  input  logic             enc_b_in,
  input  logic             sync_load_in,
  input  logic [WIDTH-1:0] count_in,
  input  logic             err_clr_in,
  output logic [WIDTH-1:0] count_out,
  output logic             step_out,
  output logic             dir_out,
  output logic             err_out
);

  localparam int             INIT_LEN  = 2 + FILTER_LEN;
  localparam logic [4:0]     INIT_LAST = 5'(INIT_LEN - 1);
  localparam logic [3:0]     FILT_LAST = 4'(FILTER_LEN - 1);
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e           state_q;
  logic [4:0]       init_cnt_q;
  logic [1:0]       sync1_q, sync2_q;   // {A, B}
  logic [1:0]       filt_q;
  logic [3:0]       fcnt_q [2];
  logic [1:0]       prev_q;
  logic [WIDTH-1:0] count_q, count_d;
  logic             step_q, step_d;
  logic             dir_q, dir_d;
  logic             err_q, err_d;

  logic             run;
  logic [1:0]       delta;

  // Gray phase {A,B} to position 0..3 along the up direction (00,10,11,01).
  function automatic logic [1:0] phase_pos(input logic [1:0] ab);
    case (ab)
      2'b00:   phase_pos = 2'd0;
      2'b10:   phase_pos = 2'd1;
      2'b11:   phase_pos = 2'd2;
      default: phase_pos = 2'd3;
    endcase
  endfunction

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else if (state_q == ST_INIT) begin
      if (init_cnt_q == INIT_LAST) begin
        state_q    <= ST_RUN;
        init_cnt_q <= '0;
      end else begin
        init_cnt_q <= init_cnt_q + 5'd1;
      end
    end
  end

  assign run = (state_q == ST_RUN);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {enc_a_in, enc_b_in};
      sync2_q <= sync1_q;
    end
  end

  // A filtered level only moves after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      filt_q    <= '0;
      fcnt_q[0] <= '0;
      fcnt_q[1] <= '0;
    end else if (!run) begin
      filt_q    <= sync2_q;
      fcnt_q[0] <= '0;
      fcnt_q[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] != filt_q[i]) begin
          if (fcnt_q[i] == FILT_LAST) begin
            filt_q[i] <= sync2_q[i];
            fcnt_q[i] <= '0;
          end else begin
            fcnt_q[i] <= fcnt_q[i] + 4'd1;
          end
        end else begin
          fcnt_q[i] <= '0;
        end
      end
    end
  end

  // delta: 1 = up, 3 = down, 2 = both phases flipped (illegal), 0 = idle.
  assign delta = phase_pos(filt_q) - phase_pos(prev_q);

  always_comb begin
    count_d = count_q;
    step_d  = 1'b0;
    dir_d   = dir_q;
    err_d   = err_q;
    if (err_clr_in)
      err_d = 1'b0;
    if (run && delta == 2'd2)
      err_d = 1'b1;
    if (sync_load_in) begin
      count_d = count_in;
    end else if (run && delta == 2'd1) begin
      count_d = count_q + ONE;
      dir_d   = 1'b1;
      step_d  = 1'b1;
    end else if (run && delta == 2'd3) begin
      count_d = count_q - ONE;
      dir_d   = 1'b0;
      step_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      prev_q  <= '0;
      count_q <= '0;
      step_q  <= 1'b0;
      dir_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      prev_q  <= filt_q;
      count_q <= count_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
    end
  end

  assign count_out = count_q;
  assign step_out  = step_q;
  assign dir_out   = dir_q;
  assign err_out   = err_q;

endmodule
